// File: rtl/banked_mem_pkg.sv
// banked_mem_pkg
// Shared defaults and helpers for the banked memory model.
//   bank_of  : bank index of a word address (low address bits)
//   be_merge : byte-lane select between stored and incoming data
package banked_mem_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_ADDRESS_WIDTH = 16;
  localparam int DEF_NUM_CH        = 2;
  localparam int DEF_NUM_BANKS     = 4;
  localparam int DEF_LATENCY       = 2;

  // num_banks is a power of two, so masking equals addr mod num_banks.
  function automatic int unsigned bank_of(input logic [31:0] addr,
                                          input int unsigned num_banks);
    return addr & (num_banks - 1);
  endfunction

  function automatic logic [7:0] be_merge(input logic [7:0] old_byte,
                                          input logic [7:0] new_byte,
                                          input logic       be);
    return be ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/banked_mem_rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter for one bank.
//   clk, rst : clock, asynchronous active-low reset
//   req      : one bit per channel requesting this bank
//   grant    : one-hot grant (combinational); pointer advances to winner+1
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic [N-1:0]  upper;
  logic [N-1:0]  pick;

  // Requests at or above the pointer take priority; if none, wrap to the
  // lowest requester. Downward scan leaves the lowest set bit granted.
  always_comb begin
    grant    = '0;
    ptr_next = ptr;
    for (int c = 0; c < N; c++) begin
      upper[c] = req[c] && (c >= int'(ptr));
    end
    pick = (|upper) ? upper : req;
    for (int c = N - 1; c >= 0; c--) begin
      if (pick[c]) begin
        grant    = '0;
        grant[c] = 1'b1;
        ptr_next = PW'((c + 1 == N) ? 0 : c + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (|req) begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/banked_mem.sv
// banked_mem
// Multi-channel, multi-bank, fixed-latency pipelined memory model.
//   clk, rst   : clock, asynchronous active-low reset
//   req_valid  : per-channel request valid
//   req_ready  : per-channel grant, combinational from requests + RR state
//   req_w      : 1 = write, 0 = read
//   req_addr   : packed word addresses, channel c at [c*ADDRESS_WIDTH +: ADDRESS_WIDTH]
//   req_wdata  : packed write data
//   req_be     : packed byte enables (writes only)
//   rsp_valid  : one-cycle pulse per accepted request, LATENCY cycles later
//   rsp_rdata  : read data for read responses, 0 otherwise
module banked_mem
  import banked_mem_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int NUM_BANKS     = DEF_NUM_BANKS,
  parameter int LATENCY       = DEF_LATENCY
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CH-1:0]               req_valid,
  output logic [NUM_CH-1:0]               req_ready,
  input  logic [NUM_CH-1:0]               req_w,
  input  logic [NUM_CH*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_CH*DATA_WIDTH/8-1:0]  req_be,
  output logic [NUM_CH-1:0]               rsp_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0]    rsp_rdata
);

  localparam int BW = DATA_WIDTH / 8;

  // Not reset: contents survive reset and are preloaded hierarchically.
  logic [DATA_WIDTH-1:0] memory [2**ADDRESS_WIDTH];

  logic [NUM_CH-1:0] bank_req [NUM_BANKS];
  logic [NUM_CH-1:0] bank_gnt [NUM_BANKS];
  logic [NUM_CH-1:0] gnt_any;
  logic [NUM_CH-1:0] accept;

  logic [LATENCY-1:0]    pipe_valid [NUM_CH];
  logic [LATENCY-1:0]    pipe_read  [NUM_CH];
  logic [DATA_WIDTH-1:0] pipe_data  [NUM_CH][LATENCY];

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_req[b] = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        bank_req[b][c] = req_valid[c] &&
          (bank_of(32'(req_addr[c*ADDRESS_WIDTH +: ADDRESS_WIDTH]),
                   unsigned'(NUM_BANKS)) == unsigned'(b));
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    rr_arbiter #(.N(NUM_CH)) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (bank_req[b]),
      .grant (bank_gnt[b])
    );
  end

  always_comb begin
    gnt_any = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      gnt_any = gnt_any | bank_gnt[b];
    end
  end

  // Grants are forced low while reset is held so nothing is accepted.
  assign req_ready = rst ? gnt_any : '0;
  assign accept    = req_valid & req_ready;

  // Two channels never write the same address in one cycle: same bank
  // requests are serialized by that bank's arbiter.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (accept[c] && req_w[c]) begin
        for (int k = 0; k < BW; k++) begin
          memory[req_addr[c*ADDRESS_WIDTH +: ADDRESS_WIDTH]][k*8 +: 8] <=
            be_merge(memory[req_addr[c*ADDRESS_WIDTH +: ADDRESS_WIDTH]][k*8 +: 8],
                     req_wdata[c*DATA_WIDTH + k*8 +: 8],
                     req_be[c*BW + k]);
        end
      end
    end
  end

  // Read data is captured at the accept edge, so later writes cannot
  // alter a read already in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        pipe_valid[c] <= '0;
        pipe_read[c]  <= '0;
        for (int s = 0; s < LATENCY; s++) begin
          pipe_data[c][s] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        pipe_valid[c][0] <= accept[c];
        pipe_read[c][0]  <= accept[c] && !req_w[c];
        pipe_data[c][0]  <= (accept[c] && !req_w[c])
                            ? memory[req_addr[c*ADDRESS_WIDTH +: ADDRESS_WIDTH]]
                            : '0;
        for (int s = 1; s < LATENCY; s++) begin
          pipe_valid[c][s] <= pipe_valid[c][s-1];
          pipe_read[c][s]  <= pipe_read[c][s-1];
          pipe_data[c][s]  <= pipe_data[c][s-1];
        end
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      rsp_valid[c] = pipe_valid[c][LATENCY-1];
      rsp_rdata[c*DATA_WIDTH +: DATA_WIDTH] =
        (pipe_valid[c][LATENCY-1] && pipe_read[c][LATENCY-1])
        ? pipe_data[c][LATENCY-1] : '0;
    end
  end

endmodule

// File: tb/tb_banked_mem.sv
// tb_banked_mem
// Directed bench for banked_mem with a transaction-level reference model
// checked every cycle, plus hand-computed expectations per scenario.
module tb_banked_mem;

  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int NCH = 2;
  localparam int NB  = 4;
  localparam int LAT = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NCH-1:0]      req_valid = '0;
  logic [NCH-1:0]      req_ready;
  logic [NCH-1:0]      req_w = '0;
  logic [NCH*AW-1:0]   req_addr = '0;
  logic [NCH*DW-1:0]   req_wdata = '0;
  logic [NCH*DW/8-1:0] req_be = '0;
  logic [NCH-1:0]      rsp_valid;
  logic [NCH*DW-1:0]   rsp_rdata;

  always #5 clk = ~clk;

  banked_mem #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_CH(NCH),
    .NUM_BANKS(NB), .LATENCY(LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_w     (req_w),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int          due;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          exp_q [NCH][$];
  logic [DW-1:0] model_mem [1 << AW];
  int            ptr_m [NB];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int addr_of(input int c);
    return int'(req_addr[c*AW +: AW]);
  endfunction

  // Reference model: at each falling edge, work out which requests the
  // coming rising edge must accept, check the DUT against it, then commit.
  always @(negedge clk) begin : compare
    logic [NCH-1:0] g;
    logic           ev;
    logic [DW-1:0]  ed;
    rsp_t           r;
    int             win;
    int             c;
    int             a;
    if (!rst) begin
      check("model_reset_ready", 64'(req_ready), 64'(0));
      check("model_reset_rsp_valid", 64'(rsp_valid), 64'(0));
      check("model_reset_rsp_rdata", 64'(rsp_rdata), 64'(0));
      for (int k = 0; k < NCH; k++) exp_q[k].delete();
      for (int b = 0; b < NB; b++) ptr_m[b] = 0;
    end else begin
      g = '0;
      for (int b = 0; b < NB; b++) begin
        win = -1;
        for (int i = 0; i < NCH; i++) begin
          c = (ptr_m[b] + i) % NCH;
          if (win < 0 && req_valid[c] && (addr_of(c) % NB) == b) win = c;
        end
        if (win >= 0) begin
          g[win]   = 1'b1;
          ptr_m[b] = (win + 1) % NCH;
        end
      end
      check("model_req_ready", 64'(req_ready), 64'(g));
      for (int k = 0; k < NCH; k++) begin
        ev = 1'b0;
        ed = '0;
        if (exp_q[k].size() > 0 && exp_q[k][0].due == cyc) begin
          ev = 1'b1;
          ed = exp_q[k][0].data;
          void'(exp_q[k].pop_front());
        end
        check("model_rsp_valid", 64'(rsp_valid[k]), 64'(ev));
        check("model_rsp_rdata", 64'(rsp_rdata[k*DW +: DW]), 64'(ed));
      end
      for (int k = 0; k < NCH; k++) begin
        if (g[k]) begin
          r.due  = cyc + LAT;
          r.data = req_w[k] ? '0 : model_mem[addr_of(k)];
          exp_q[k].push_back(r);
        end
      end
      for (int k = 0; k < NCH; k++) begin
        if (g[k] && req_w[k]) begin
          a = addr_of(k);
          for (int j = 0; j < DW/8; j++)
            if (req_be[k*(DW/8) + j]) model_mem[a][j*8 +: 8] = req_wdata[k*DW + j*8 +: 8];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input int c, input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d = '0, input logic [DW/8-1:0] be = '0);
    req_valid[c]            = v;
    req_w[c]                = w;
    req_addr[c*AW +: AW]    = a;
    req_wdata[c*DW +: DW]   = d;
    req_be[c*(DW/8) +: DW/8] = be;
  endtask

  task automatic preload(input int a, input logic [DW-1:0] v);
    dut.memory[a] = v;
    model_mem[a]  = v;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) preload(i, '0);
    for (int b = 0; b < NB; b++) ptr_m[b] = 0;
    preload('h0004, 32'h44);
    preload('h0008, 32'h88);
    preload('h000C, 32'hCC);
    preload('h0001, 32'hA1);
    preload('h0002, 32'hB2);
    preload('h0100, 32'd7);
    preload('h0010, 32'h11223344);
    preload('h0020, 32'h5A5A);

    // Reset: grants held low even with valid requests.
    #2 rst = 1'b0;
    drive(0, 1, 0, 16'h0004);
    drive(1, 1, 0, 16'h0008);
    tick(); settle();
    check("reset_ready", 64'(req_ready), 64'(0));
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_rsp_rdata", 64'(rsp_rdata), 64'(0));
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    tick();
    rst = 1'b1;
    tick();

    // Bank-0 conflict with round-robin fairness.
    drive(0, 1, 0, 16'h0004);
    drive(1, 1, 0, 16'h0008);
    settle();
    check("conflict_first", 64'(req_ready), 64'(2'b01));
    tick();
    drive(0, 1, 0, 16'h000C);
    settle();
    check("conflict_second", 64'(req_ready), 64'(2'b10));
    tick();
    drive(1, 0, 0, 0);
    settle();
    check("conflict_third", 64'(req_ready), 64'(2'b01));
    tick();
    drive(0, 0, 0, 0);
    tick(); tick(); tick();

    // Different banks, same cycle.
    drive(0, 1, 0, 16'h0001);
    drive(1, 1, 0, 16'h0002);
    settle();
    check("noconf_ready", 64'(req_ready), 64'(2'b11));
    tick();
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    settle();
    check("noconf_early", 64'(rsp_valid), 64'(0));
    tick(); settle();
    check("noconf_rsp_valid", 64'(rsp_valid), 64'(2'b11));
    check("noconf_rsp_rdata", 64'(rsp_rdata), {32'hB2, 32'hA1});
    tick();

    // Single read, latency 2.
    drive(0, 1, 0, 16'h0100);
    settle();
    check("single_ready", 64'(req_ready), 64'(2'b01));
    tick();
    drive(0, 0, 0, 0);
    tick(); settle();
    check("single_rsp_valid", 64'(rsp_valid), 64'(2'b01));
    check("single_rsp_rdata", 64'(rsp_rdata[31:0]), 64'(7));
    tick(); settle();
    check("single_rsp_done", 64'(rsp_valid), 64'(0));
    tick();

    // Byte-enabled write then read back.
    drive(0, 1, 1, 16'h0010, 32'hAABBCCDD, 4'b0101);
    settle();
    check("be_write_ready", 64'(req_ready), 64'(2'b01));
    tick();
    drive(0, 1, 0, 16'h0010);
    tick();
    drive(0, 0, 0, 0);
    settle();
    check("be_write_rsp_valid", 64'(rsp_valid), 64'(2'b01));
    check("be_write_rsp_rdata", 64'(rsp_rdata), 64'(0));
    tick(); settle();
    check("be_read_rsp_valid", 64'(rsp_valid), 64'(2'b01));
    check("be_read_rsp_rdata", 64'(rsp_rdata[31:0]), 64'h11BB33DD);
    tick();

    // Cross-channel write-then-read.
    drive(1, 1, 1, 16'h0021, 32'hDEADBEEF, 4'b1111);
    tick();
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 16'h0021);
    tick();
    drive(0, 0, 0, 0);
    tick(); settle();
    check("xch_rsp_rdata", 64'(rsp_rdata[31:0]), 64'hDEADBEEF);
    tick();

    // Streaming 16 back-to-back reads.
    for (int i = 0; i < 16; i++) preload('h0100 + i, DW'(i + 1));
    for (int i = 0; i < 18; i++) begin
      if (i < 16) drive(0, 1, 0, AW'(16'h0100 + i));
      else        drive(0, 0, 0, 0);
      settle();
      if (i < 16) check("stream_ready", 64'(req_ready[0]), 64'(1));
      if (i >= 2) begin
        check("stream_rsp_valid", 64'(rsp_valid[0]), 64'(1));
        check("stream_rsp_rdata", 64'(rsp_rdata[31:0]), 64'(i - 1));
      end
      tick();
    end
    settle();
    check("stream_done", 64'(rsp_valid), 64'(0));
    tick();

    // Reset mid-operation flushes the in-flight read.
    drive(1, 1, 0, 16'h0020);
    settle();
    check("rstmid_ready", 64'(req_ready), 64'(2'b10));
    tick();
    drive(1, 0, 0, 0);
    rst = 1'b0;
    settle();
    check("rstmid_flush", 64'(rsp_valid), 64'(0));
    tick();
    drive(0, 1, 0, 16'h0004);
    drive(1, 1, 0, 16'h0001);
    settle();
    check("rstmid_ready_low", 64'(req_ready), 64'(0));
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    tick();
    rst = 1'b1;
    settle();
    check("rstmid_after_release", 64'(rsp_valid), 64'(0));
    tick(); settle();
    check("rstmid_no_pulse", 64'(rsp_valid), 64'(0));
    tick();
    drive(1, 1, 0, 16'h0020);
    settle();
    check("rstmid_reread_ready", 64'(req_ready), 64'(2'b10));
    tick();
    drive(1, 0, 0, 0);
    tick(); settle();
    check("rstmid_reread_valid", 64'(rsp_valid), 64'(2'b10));
    check("rstmid_reread_rdata", 64'(rsp_rdata[63:32]), 64'h5A5A);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
